// File: rtl/frame_rate_cfg_sequencer.sv
// Purpose : classify the measured frame rate into a band, debounce it over frames, and push a
//           4-entry HDMI-transmitter register burst to the config master whenever the stable band changes.
// Latency : frame tick 2 clk after the vsync rising edge; burst starts the cycle after the committing tick.
// Backpr. : each write holds req/addr/data until ack or err; frame ticks are ignored while a burst is in flight.
//
// Ports
//   clk, reset                      : clock, synchronous active-high reset
//   i_vsync                         : raw vsync, synchronised and edge-detected here
//   i_freq[6:0], i_freq_valid       : measured frame rate in Hz and its qualifier
//   o_cfg_req/o_cfg_addr/o_cfg_data : register write request to the config master
//   i_cfg_ack, i_cfg_err            : 1-cycle write completion / NAK pulses
//   o_band                          : committed band (0 none, 1 50Hz, 2 60Hz, 3 HI)
//   o_busy                          : high while a burst is in progress
//   o_fail                          : sticky; set when retries run out, cleared by the next good burst
module frame_rate_cfg_sequencer #(
    parameter int unsigned STABLE_FRAMES = 8,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [31:0] TBL_ADDR      = 32'h17_16_AF_D5,
    parameter logic [31:0] TBL_DATA_50   = 32'h02_30_06_80,
    parameter logic [31:0] TBL_DATA_60   = 32'h00_30_06_80,
    parameter logic [31:0] TBL_DATA_HI   = 32'h00_34_16_80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_vsync,
    input  logic [6:0] i_freq,
    input  logic       i_freq_valid,
    output logic       o_cfg_req,
    output logic [7:0] o_cfg_addr,
    output logic [7:0] o_cfg_data,
    input  logic       i_cfg_ack,
    input  logic       i_cfg_err,
    output logic [1:0] o_band,
    output logic       o_busy,
    output logic       o_fail
);

    localparam logic [7:0] LP_STABLE    = 8'(STABLE_FRAMES);
    localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DONE     = 3'd3,
        S_FAIL     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_vs_meta;
    logic        r_vs_sync;
    logic        r_vs_prev;
    logic        w_tick;

    logic [1:0]  w_class;
    logic [1:0]  r_cand;
    logic [1:0]  w_cand_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        w_commit;

    logic [1:0]  r_idx;
    logic [3:0]  r_retry;
    logic [3:0]  w_retry_inc;
    logic [31:0] r_tbl_data;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic [1:0]  r_band;
    logic        r_fail;

    // vsync synchroniser; tick is the first cycle the synchronised level is seen high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= i_vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_tick = r_vs_sync & ~r_vs_prev;

    always_comb begin
        w_class = 2'd0;
        if (i_freq_valid) begin
            if (i_freq >= 7'd45 && i_freq <= 7'd54) begin
                w_class = 2'd1;
            end else if (i_freq >= 7'd55 && i_freq <= 7'd64) begin
                w_class = 2'd2;
            end else if (i_freq >= 7'd65 && i_freq <= 7'd80) begin
                w_class = 2'd3;
            end
        end
    end

    // Debounce: a band must repeat on consecutive ticks; losing the signal restarts qualification
    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (w_tick) begin
            if (w_class == 2'd0) begin
                w_cand_nxt = 2'd0;
                w_cnt_nxt  = 8'd0;
            end else if (w_class != r_cand) begin
                w_cand_nxt = w_class;
                w_cnt_nxt  = 8'd1;
            end else if (r_cnt != 8'hFF) begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
        end
    end

    assign w_commit = (r_state == S_IDLE) && w_tick && (w_cnt_nxt == LP_STABLE) &&
                      (w_cand_nxt != r_band) && (w_cand_nxt != 2'd0);

    assign w_retry_inc = r_retry + 4'd1;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state; err takes priority over a simultaneous ack
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_commit) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_cfg_err) begin
                    w_state_nxt = (w_retry_inc <= LP_MAX_RETRY) ? S_WRITE : S_FAIL;
                end else if (i_cfg_ack) begin
                    w_state_nxt = (r_idx == 2'd3) ? S_DONE : S_WRITE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. WRITE is a setup cycle with req low, so req always drops between entries.
    always_comb begin
        o_cfg_req = (r_state == S_WAIT_ACK);
        o_busy    = (r_state == S_WRITE) || (r_state == S_WAIT_ACK);
    end

    // Datapath: debounce state, burst index, retry count, latched table, committed band
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand     <= 2'd0;
            r_cnt      <= 8'd0;
            r_idx      <= 2'd0;
            r_retry    <= 4'd0;
            r_tbl_data <= 32'd0;
            r_addr     <= 8'd0;
            r_data     <= 8'd0;
            r_band     <= 2'd0;
            r_fail     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cand <= w_cand_nxt;
                    r_cnt  <= w_cnt_nxt;
                    if (w_commit) begin
                        r_idx <= 2'd0;
                        // Table is frozen here so the whole burst uses one band's data
                        case (w_cand_nxt)
                            2'd1:    r_tbl_data <= TBL_DATA_50;
                            2'd2:    r_tbl_data <= TBL_DATA_60;
                            default: r_tbl_data <= TBL_DATA_HI;
                        endcase
                    end
                end
                S_WRITE: begin
                    r_addr <= TBL_ADDR[{r_idx, 3'b000} +: 8];
                    r_data <= r_tbl_data[{r_idx, 3'b000} +: 8];
                end
                S_WAIT_ACK: begin
                    if (i_cfg_err) begin
                        r_retry <= w_retry_inc;
                        r_idx   <= 2'd0;
                    end else if (i_cfg_ack && r_idx != 2'd3) begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                S_DONE: begin
                    r_band  <= r_cand;
                    r_fail  <= 1'b0;
                    r_retry <= 4'd0;
                    r_cnt   <= 8'd0;
                end
                S_FAIL: begin
                    r_fail  <= 1'b1;
                    r_retry <= 4'd0;
                    r_cnt   <= 8'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cfg_addr = r_addr;
    assign o_cfg_data = r_data;
    assign o_band     = r_band;
    assign o_fail     = r_fail;

endmodule

// File: tb/tb_frame_rate_cfg_sequencer.sv
module tb_frame_rate_cfg_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_vsync = 1'b0;
    logic [6:0] i_freq = 7'd0;
    logic       i_freq_valid = 1'b0;
    logic       o_cfg_req;
    logic [7:0] o_cfg_addr;
    logic [7:0] o_cfg_data;
    logic       i_cfg_ack = 1'b0;
    logic       i_cfg_err = 1'b0;
    logic [1:0] o_band;
    logic       o_busy;
    logic       o_fail;

    frame_rate_cfg_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .i_vsync      (i_vsync),
        .i_freq       (i_freq),
        .i_freq_valid (i_freq_valid),
        .o_cfg_req    (o_cfg_req),
        .o_cfg_addr   (o_cfg_addr),
        .o_cfg_data   (o_cfg_data),
        .i_cfg_ack    (i_cfg_ack),
        .i_cfg_err    (i_cfg_err),
        .o_band       (o_band),
        .o_busy       (o_busy),
        .o_fail       (o_fail)
    );

    always #5 clk = ~clk;

    localparam int FRAME_CYC = 40;
    localparam int M_ACK = 0, M_ERR_ONCE = 1, M_ERR_ALL = 2, M_HOLD = 3;

    int          n_pass = 0;
    int          n_total = 0;
    int          resp_mode = M_ACK;
    int          req_wait = 0;
    logic        prev_req = 1'b0;
    logic [15:0] held;
    logic [15:0] exp_q[$];

    // Expected writes per band: {addr, data} for entries 0..3
    logic [7:0] exp_addr[4] = '{8'hD5, 8'hAF, 8'h16, 8'h17};
    logic [7:0] exp_d50[4]  = '{8'h80, 8'h06, 8'h30, 8'h02};
    logic [7:0] exp_d60[4]  = '{8'h80, 8'h06, 8'h30, 8'h00};

    task automatic push_writes(input int band, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({exp_addr[k], (band == 1) ? exp_d50[k] : exp_d60[k]});
        end
    endtask

    // One clock of the config-master model: scoreboard each new request, hold-check, respond
    task automatic cyc();
        @(negedge clk);
        if (o_cfg_req && !prev_req) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_req: got addr=%h data=%h, required no request", o_cfg_addr, o_cfg_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({o_cfg_addr, o_cfg_data} !== e)
                    $display("FAIL write_entry: got addr/data=%h, required %h", {o_cfg_addr, o_cfg_data}, e);
                else
                    n_pass++;
            end
            held     = {o_cfg_addr, o_cfg_data};
            req_wait = 0;
        end else if (o_cfg_req) begin
            n_total++;
            if ({o_cfg_addr, o_cfg_data} !== held)
                $display("FAIL req_hold: addr/data moved to %h, required %h", {o_cfg_addr, o_cfg_data}, held);
            else
                n_pass++;
        end
        i_cfg_ack = 1'b0;
        i_cfg_err = 1'b0;
        if (o_cfg_req) begin
            req_wait++;
            if (req_wait == 2 && resp_mode != M_HOLD) begin
                if (resp_mode == M_ERR_ALL) begin
                    i_cfg_err = 1'b1;
                end else if (resp_mode == M_ERR_ONCE && o_cfg_addr == 8'h16) begin
                    i_cfg_err = 1'b1;
                    i_cfg_ack = 1'b1;   // err with ack: ack must be ignored
                    resp_mode = M_ACK;
                end else begin
                    i_cfg_ack = 1'b1;
                end
            end
        end
        prev_req = o_cfg_req;
    endtask

    task automatic frames(input int n, input logic [6:0] f, input logic v);
        i_freq       = f;
        i_freq_valid = v;
        for (int i = 0; i < n; i++) begin
            i_vsync = 1'b1;
            cyc();
            cyc();
            i_vsync = 1'b0;
            for (int c = 2; c < FRAME_CYC; c++) cyc();
        end
    endtask

    task automatic settle();
        int t;
        t = 0;
        while (o_busy && t < 200) begin
            cyc();
            t++;
        end
        n_total++;
        if (o_busy) $display("FAIL settle_timeout: o_busy=%b after %0d cycles, required 0", o_busy, t);
        else n_pass++;
        repeat (4) cyc();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL missing_writes: %0d outstanding, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({o_cfg_req, o_busy, o_fail} !== 3'b000)
            $display("FAIL reset_ctrl: req/busy/fail=%b, required 000", {o_cfg_req, o_busy, o_fail});
        else n_pass++;
        n_total++;
        if ({o_cfg_addr, o_cfg_data} !== 16'h0000)
            $display("FAIL reset_bus: addr/data=%h, required 0000", {o_cfg_addr, o_cfg_data});
        else n_pass++;
        n_total++;
        if (o_band !== 2'd0) $display("FAIL reset_band: o_band=%0d, required 0", o_band);
        else n_pass++;
    endtask

    task automatic test_single_burst();
        push_writes(1, 4);
        frames(7, 7'd50, 1'b1);
        n_total++;
        if (exp_q.size() != 4 || o_band !== 2'd0)
            $display("FAIL early_commit: pending=%0d band=%0d after 7 frames, required 4 and 0", exp_q.size(), o_band);
        else n_pass++;
        frames(1, 7'd50, 1'b1);
        settle();
        n_total++;
        if (o_band !== 2'd1 || o_fail !== 1'b0)
            $display("FAIL band50: band=%0d fail=%b, required 1 and 0", o_band, o_fail);
        else n_pass++;
    endtask

    task automatic test_band_change();
        do_reset();
        frames(5, 7'd50, 1'b1);
        push_writes(2, 4);
        frames(8, 7'd60, 1'b1);
        settle();
        n_total++;
        if (o_band !== 2'd2) $display("FAIL band60: band=%0d, required 2", o_band);
        else n_pass++;
    endtask

    task automatic test_same_band();
        frames(20, 7'd61, 1'b1);
        settle();
        n_total++;
        if (o_band !== 2'd2) $display("FAIL same_band: band=%0d, required 2", o_band);
        else n_pass++;
    endtask

    task automatic test_signal_lost();
        frames(10, 7'd50, 1'b0);
        frames(10, 7'd100, 1'b1);
        settle();
        n_total++;
        if (o_band !== 2'd2) $display("FAIL signal_lost: band=%0d, required 2", o_band);
        else n_pass++;
    endtask

    task automatic test_err_once();
        resp_mode = M_ERR_ONCE;
        push_writes(1, 3);
        push_writes(1, 4);
        frames(8, 7'd50, 1'b1);
        settle();
        n_total++;
        if (o_band !== 2'd1 || o_fail !== 1'b0)
            $display("FAIL err_once: band=%0d fail=%b, required 1 and 0", o_band, o_fail);
        else n_pass++;
    endtask

    task automatic test_err_all();
        resp_mode = M_ERR_ALL;
        push_writes(2, 1);
        push_writes(2, 1);
        push_writes(2, 1);
        push_writes(2, 1);
        frames(8, 7'd60, 1'b1);
        settle();
        n_total++;
        if (o_fail !== 1'b1 || o_band !== 2'd1)
            $display("FAIL retry_exhaust: fail=%b band=%0d, required 1 and 1", o_fail, o_band);
        else n_pass++;
    endtask

    task automatic test_recover();
        resp_mode = M_ACK;
        push_writes(2, 4);
        frames(8, 7'd60, 1'b1);
        settle();
        n_total++;
        if (o_fail !== 1'b0 || o_band !== 2'd2)
            $display("FAIL recover: fail=%b band=%0d, required 0 and 2", o_fail, o_band);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int t;
        resp_mode = M_HOLD;
        push_writes(1, 1);
        frames(7, 7'd50, 1'b1);
        i_vsync = 1'b1;
        t = 0;
        while (!o_cfg_req && t < FRAME_CYC) begin
            cyc();
            t++;
            if (t == 2) i_vsync = 1'b0;
        end
        i_vsync = 1'b0;
        n_total++;
        if (!o_cfg_req) $display("FAIL req_timeout: o_cfg_req=%b after %0d cycles, required 1", o_cfg_req, t);
        else n_pass++;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        n_total++;
        if ({o_cfg_req, o_busy} !== 2'b00 || o_band !== 2'd0)
            $display("FAIL reset_mid: req/busy=%b band=%0d, required 00 and 0", {o_cfg_req, o_busy}, o_band);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        i_cfg_ack = 1'b1;
        @(negedge clk);
        i_cfg_ack = 1'b0;
        repeat (20) cyc();
        n_total++;
        if ({o_cfg_req, o_busy} !== 2'b00 || o_band !== 2'd0)
            $display("FAIL stray_ack: req/busy=%b band=%0d, required 00 and 0", {o_cfg_req, o_busy}, o_band);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_band_change();
        test_same_band();
        test_signal_lost();
        test_err_once();
        test_err_all();
        test_recover();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
